sys_cfg_rx: RTL
===============

SYS_CFG_RX -- requirements
Module: sys_cfg_rx

Interface
REQ-001 Parameter CFG_DEFAULT, default 16'h0000: value loaded into cfg on reset.
REQ-002 Parameter FW_VER, default 8'h01: version byte returned by the status command.
REQ-003 Port clk_sys, input, 1: the single clock; every register samples on its rising edge.
REQ-004 Port reset, input, 1: asynchronous active-high reset.
REQ-005 Port io_clk, input, 1: HPS word clock; already synchronised to clk_sys upstream; each 0->1 transition delivers one word.
REQ-006 Port io_uio, input, 1: HPS command-frame enable; high for the whole frame.
REQ-007 Port io_din, input, 16: HPS write word, valid when io_strobe=1.
REQ-008 Port io_strobe, output, 1: one-cycle word pulse.
REQ-009 Port io_ack, output, 1: acknowledge returned to HPS.
REQ-010 Port io_dout, output, 16: read word presented to HPS.
REQ-011 Port cfg, output, 16: system configuration word.
REQ-012 Port cfg_ready, output, 1: set once the first cfg word has been received.
REQ-013 Port arx, output, 8: horizontal aspect-ratio value.
REQ-014 Port ary, output, 8: vertical aspect-ratio value.
REQ-015 Port bad_cmd, output, 1: one-cycle pulse when an unknown command byte is received.

Function
REQ-016 Handshake registers: rack <= io_clk and io_ack <= rack, every cycle.
REQ-017 io_strobe = io_clk & ~rack (combinational); the pulse is exactly one cycle per io_clk rising edge.
REQ-018 The decoder has two states: IDLE (no command) and CMD (command latched, word counter wcnt[3:0] active).
REQ-019 In any state, io_uio=0 forces IDLE on the next edge and sets wcnt=0; this has priority over a simultaneous io_strobe.
REQ-020 IDLE with io_uio=1 and io_strobe: latch cmd=io_din[7:0], set wcnt=0, enter CMD.
REQ-021 If that byte is not 01, 02 or 03: pulse bad_cmd for one cycle and enter CMD anyway; all further words in the frame are ignored.
REQ-022 CMD with io_strobe: process the word indexed by wcnt, then increment wcnt, saturating at 15; words at index 15 and above are all treated as index 15.
REQ-023 Command 01, word 0: cfg <= io_din and cfg_ready <= 1; words at index 1 and above are ignored.
REQ-024 Command 02, word 0: arx <= io_din[7:0] and ary <= io_din[15:8]; later words are ignored.
REQ-025 Command 03 (status read), io_dout source by phase:
  - on entry to CMD: {8'hA4, FW_VER};
  - after word 0 strobe: cfg;
  - after word 1 strobe: {ary, arx};
  - after word 2 strobe and beyond: 16'h0000.
REQ-026 io_dout is registered; its update lands on the same edge that consumes the strobe.
REQ-027 io_dout = 0 whenever the state is IDLE, or the latched cmd is not 03.
REQ-028 cfg_ready, once set, stays set until reset.
REQ-029 cfg, arx and ary change only on the qualifying strobe edges above; an aborted frame leaves them unchanged.

Reset
REQ-030 On reset assertion, all of the following are set immediately, independent of clk_sys:
  - rack=0, io_ack=0;
  - state=IDLE, wcnt=0, cmd=0;
  - cfg=CFG_DEFAULT, cfg_ready=0;
  - arx=0, ary=0;
  - io_dout=0, bad_cmd=0.
REQ-031 Reset asserted mid-frame discards the frame; after release, decoding resumes only with the next command word seen while io_uio=1.

Verification
REQ-032 Frame io_uio=1, words 0x0001 then 0x0064 -> cfg=16'h0064; cfg_ready=1 one cycle after the second strobe; io_strobe pulses exactly twice.
REQ-033 Frame cmd 0x0002 then 0x0910 -> arx=8'h10, ary=8'h09; a third word 0xFFFF leaves both unchanged.
REQ-034 After REQ-032/033, frame cmd 0x0003 with three read strobes -> io_dout sequence {0xA401, 0x0064, 0x0910, 0x0000}; io_dout=0 after io_uio drops.
REQ-035 cmd 0x00FF -> bad_cmd single-cycle pulse; the following word 0x1234 does not change cfg, arx or ary.
REQ-036 io_uio dropped on the same cycle as the cmd-01 data strobe -> cfg and cfg_ready unchanged; the next frame decodes normally.
REQ-037 Reset asserted between the cmd 0x0001 word and the data word -> cfg=CFG_DEFAULT and cfg_ready=0; a data word in the same frame after release is treated as a new command byte.

Source files
------------

// File: rtl/sys_cfg_rx.sv
// sys_cfg_rx: HPS command-frame receiver.
// Decodes config, aspect-ratio and status-read commands from word strobes.
module sys_cfg_rx #(
    parameter logic [15:0] CFG_DEFAULT = 16'h0000,
    parameter logic [7:0]  FW_VER      = 8'h01
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        io_clk,
    input  logic        io_uio,
    input  logic [15:0] io_din,
    output logic        io_strobe,
    output logic        io_ack,
    output logic [15:0] io_dout,
    output logic [15:0] cfg,
    output logic        cfg_ready,
    output logic [7:0]  arx,
    output logic [7:0]  ary,
    output logic        bad_cmd
);

    typedef enum logic {
        IDLE = 1'b0,
        CMD  = 1'b1
    } state_t;

    localparam logic [7:0] CMD_CFG  = 8'h01;
    localparam logic [7:0] CMD_AR   = 8'h02;
    localparam logic [7:0] CMD_STAT = 8'h03;

    logic        rack_q;
    logic        ack_q;
    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] cfg_q, cfg_d;
    logic        cfg_ready_q, cfg_ready_d;
    logic [7:0]  arx_q, arx_d;
    logic [7:0]  ary_q, ary_d;
    logic [15:0] dout_q, dout_d;
    logic        bad_q, bad_d;

    assign io_strobe = io_clk & ~rack_q;
    assign io_ack    = ack_q;
    assign io_dout   = dout_q;
    assign cfg       = cfg_q;
    assign cfg_ready = cfg_ready_q;
    assign arx       = arx_q;
    assign ary       = ary_q;
    assign bad_cmd   = bad_q;

    // State and data registers; reset is asynchronous.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            rack_q      <= 1'b0;
            ack_q       <= 1'b0;
            state_q     <= IDLE;
            wcnt_q      <= 4'd0;
            cmd_q       <= 8'h00;
            cfg_q       <= CFG_DEFAULT;
            cfg_ready_q <= 1'b0;
            arx_q       <= 8'h00;
            ary_q       <= 8'h00;
            dout_q      <= 16'h0000;
            bad_q       <= 1'b0;
        end else begin
            rack_q      <= io_clk;
            ack_q       <= rack_q;
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            cmd_q       <= cmd_d;
            cfg_q       <= cfg_d;
            cfg_ready_q <= cfg_ready_d;
            arx_q       <= arx_d;
            ary_q       <= ary_d;
            dout_q      <= dout_d;
            bad_q       <= bad_d;
        end
    end

    // Next-state decode: frame abort first, then command or data word.
    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        cmd_d       = cmd_q;
        cfg_d       = cfg_q;
        cfg_ready_d = cfg_ready_q;
        arx_d       = arx_q;
        ary_d       = ary_q;
        dout_d      = dout_q;
        bad_d       = 1'b0;

        if (!io_uio) begin
            state_d = IDLE;
            wcnt_d  = 4'd0;
            dout_d  = 16'h0000;
        end else if (io_strobe) begin
            unique case (state_q)
                IDLE: begin
                    cmd_d   = io_din[7:0];
                    wcnt_d  = 4'd0;
                    state_d = CMD;
                    bad_d   = !(io_din[7:0] == CMD_CFG ||
                                io_din[7:0] == CMD_AR  ||
                                io_din[7:0] == CMD_STAT);
                    if (io_din[7:0] == CMD_STAT)
                        dout_d = {8'hA4, FW_VER};
                    else
                        dout_d = 16'h0000;
                end
                CMD: begin
                    if (wcnt_q != 4'hF)
                        wcnt_d = wcnt_q + 4'd1;
                    case (cmd_q)
                        CMD_CFG: begin
                            if (wcnt_q == 4'd0) begin
                                cfg_d       = io_din;
                                cfg_ready_d = 1'b1;
                            end
                        end
                        CMD_AR: begin
                            if (wcnt_q == 4'd0) begin
                                arx_d = io_din[7:0];
                                ary_d = io_din[15:8];
                            end
                        end
                        CMD_STAT: begin
                            case (wcnt_q)
                                4'd0:    dout_d = cfg_q;
                                4'd1:    dout_d = {ary_q, arx_q};
                                default: dout_d = 16'h0000;
                            endcase
                        end
                        default: dout_d = 16'h0000;
                    endcase
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q == IDLE) begin
            dout_d = 16'h0000;
        end
    end

endmodule
